// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine datapath.
//   - state_e    : 2-bit FSM encoding (Idle, Collect, Dispense, Change)
//   - Coin*      : coin_type codes; CoinInvalid is never accepted
//   - Default*   : default coin values and item price
package vending_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StCollect  = 2'b01,
        StDispense = 2'b10,
        StChange   = 2'b11
    } state_e;

    localparam logic [1:0] CoinA       = 2'b00;
    localparam logic [1:0] CoinB       = 2'b01;
    localparam logic [1:0] CoinC       = 2'b10;
    localparam logic [1:0] CoinInvalid = 2'b11;

    localparam int unsigned DefaultCreditW = 8;
    localparam int unsigned DefaultPrice   = 15;
    localparam int unsigned DefaultCoinA   = 5;
    localparam int unsigned DefaultCoinB   = 10;
    localparam int unsigned DefaultCoinC   = 20;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder cell.
//   a_i, b_i : operand bits
//   sum_o    : a_i ^ b_i
//   carry_o  : a_i & b_i
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;

endmodule

// File: rtl/ripple_adder_n.sv
// N-bit ripple-carry adder built from half_adder cells. Each bit is a full adder made of
// two half adders whose carries are OR-merged (they can never both be 1).
//   a_i, b_i : N-bit operands
//   sum_o    : N-bit sum
//   carry_o  : carry out of the MSB
module ripple_adder_n #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o,
    output logic         carry_o
);

    logic [N:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic s_ab;
        logic c_ab;
        logic c_sc;

        half_adder u_ha_ab (
            .a_i     (a_i[i]),
            .b_i     (b_i[i]),
            .sum_o   (s_ab),
            .carry_o (c_ab)
        );

        half_adder u_ha_sc (
            .a_i     (s_ab),
            .b_i     (carry[i]),
            .sum_o   (sum_o[i]),
            .carry_o (c_sc)
        );

        assign carry[i+1] = c_ab | c_sc;
    end

    assign carry_o = carry[N];

endmodule

// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator: front end of the vending datapath. Accumulates coin credit,
// pulses dispense_o when the price is reached and returns excess credit as change.
// Optional macro CHANGE_RETURN_EN builds the change/refund path; without it excess credit
// is forfeited and cancel simply clears credit.
// Ports:
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   coin_valid_i/type_i   : coin offer; coin_ready_o accepts it (low while busy or cancelling)
//   cancel_i              : level request to refund accumulated credit
//   dispense_o            : one-cycle release pulse
//   change_valid_o/amount : change or refund, held until change_ack_i
//   coin_reject_o         : one-cycle pulse for an invalid or overflowing coin
//   credit_o              : registered credit; busy_o high in Dispense or Change
module coin_credit_accumulator
    import vending_pkg::*;
#(
    parameter int unsigned CREDIT_W   = DefaultCreditW,
    parameter int unsigned PRICE      = DefaultPrice,
    parameter int unsigned COIN_A_VAL = DefaultCoinA,
    parameter int unsigned COIN_B_VAL = DefaultCoinB,
    parameter int unsigned COIN_C_VAL = DefaultCoinC
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                coin_valid_i,
    input  logic [1:0]          coin_type_i,
    output logic                coin_ready_o,
    input  logic                cancel_i,
    output logic                dispense_o,
    output logic                change_valid_o,
    output logic [CREDIT_W-1:0] change_amount_o,
    input  logic                change_ack_i,
    output logic                coin_reject_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                busy_o
);

    localparam int unsigned       CreditMax = (32'd1 << CREDIT_W) - 32'd1;
    localparam logic [CREDIT_W:0] PriceExt  = PRICE[CREDIT_W:0];

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;

    logic [CREDIT_W-1:0] coin_val;
    logic                coin_bad;
    logic [CREDIT_W-1:0] sum;
    logic                sum_carry;
    logic                accepting;

    // A coin value that does not fit the credit width can never be added without overflow.
    always_comb begin
        coin_val = '0;
        coin_bad = 1'b0;
        unique case (coin_type_i)
            CoinA: begin
                coin_val = COIN_A_VAL[CREDIT_W-1:0];
                coin_bad = (COIN_A_VAL > CreditMax);
            end
            CoinB: begin
                coin_val = COIN_B_VAL[CREDIT_W-1:0];
                coin_bad = (COIN_B_VAL > CreditMax);
            end
            CoinC: begin
                coin_val = COIN_C_VAL[CREDIT_W-1:0];
                coin_bad = (COIN_C_VAL > CreditMax);
            end
            default: coin_bad = 1'b1;
        endcase
    end

    ripple_adder_n #(
        .N (CREDIT_W)
    ) u_adder (
        .a_i     (credit_q),
        .b_i     (coin_val),
        .sum_o   (sum),
        .carry_o (sum_carry)
    );

    assign accepting = (state_q == StIdle) || (state_q == StCollect);

`ifdef CHANGE_RETURN_EN
    logic [CREDIT_W-1:0] excess;
    assign excess = credit_q - PRICE[CREDIT_W-1:0];
`else
    logic unused_change_ack;
    assign unused_change_ack = change_ack_i;
`endif

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        unique case (state_q)
            StIdle, StCollect: begin
                // cancel wins over a simultaneous coin: no transfer, no reject
                if (cancel_i) begin
                    if (state_q == StCollect && credit_q != '0) begin
`ifdef CHANGE_RETURN_EN
                        state_d = StChange;
`else
                        state_d  = StIdle;
                        credit_d = '0;
`endif
                    end
                end else if (coin_valid_i) begin
                    if (coin_bad || sum_carry) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = sum;
                        state_d  = ({sum_carry, sum} >= PriceExt) ? StDispense : StCollect;
                    end
                end
            end
            StDispense: begin
`ifdef CHANGE_RETURN_EN
                if (excess != '0) begin
                    state_d  = StChange;
                    credit_d = excess;
                end else begin
                    state_d  = StIdle;
                    credit_d = '0;
                end
`else
                state_d  = StIdle;
                credit_d = '0;
`endif
            end
            StChange: begin
`ifdef CHANGE_RETURN_EN
                if (change_ack_i) begin
                    state_d  = StIdle;
                    credit_d = '0;
                end
`else
                state_d  = StIdle;
                credit_d = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    assign coin_ready_o  = accepting && !cancel_i;
    assign dispense_o    = (state_q == StDispense);
    assign coin_reject_o = reject_q;
    assign credit_o      = credit_q;

`ifdef CHANGE_RETURN_EN
    assign change_valid_o  = (state_q == StChange);
    assign change_amount_o = (state_q == StChange) ? credit_q : '0;
`else
    assign change_valid_o  = 1'b0;
    assign change_amount_o = '0;
`endif

    assign busy_o = (state_q == StDispense) || change_valid_o;

endmodule

// File: tb/tb_coin_credit_accumulator.sv
module tb_coin_credit_accumulator;

`ifdef CHANGE_RETURN_EN
    localparam bit Chg = 1'b1;
`else
    localparam bit Chg = 1'b0;
`endif
    localparam int Price = 15;
    localparam int CreditMax = 255;

    logic       clk;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       coin_ready;
    logic       cancel;
    logic       dispense;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       change_ack;
    logic       coin_reject;
    logic [7:0] credit;
    logic       busy;

    // narrow instance for the overflow boundary
    logic       s_valid;
    logic [1:0] s_type;
    logic       s_ready;
    logic       s_dispense;
    logic       s_change_valid;
    logic [3:0] s_change_amount;
    logic       s_reject;
    logic [3:0] s_credit;
    logic       s_busy;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: credit as plain integer plus "dispensing" and "returning" flags
    int m_credit;
    bit m_disp;
    bit m_ret;
    bit m_reject;

    coin_credit_accumulator u_dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .coin_valid_i    (coin_valid),
        .coin_type_i     (coin_type),
        .coin_ready_o    (coin_ready),
        .cancel_i        (cancel),
        .dispense_o      (dispense),
        .change_valid_o  (change_valid),
        .change_amount_o (change_amount),
        .change_ack_i    (change_ack),
        .coin_reject_o   (coin_reject),
        .credit_o        (credit),
        .busy_o          (busy)
    );

    coin_credit_accumulator #(
        .CREDIT_W (4),
        .PRICE    (15)
    ) u_dut_w4 (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .coin_valid_i    (s_valid),
        .coin_type_i     (s_type),
        .coin_ready_o    (s_ready),
        .cancel_i        (1'b0),
        .dispense_o      (s_dispense),
        .change_valid_o  (s_change_valid),
        .change_amount_o (s_change_amount),
        .change_ack_i    (1'b0),
        .coin_reject_o   (s_reject),
        .credit_o        (s_credit),
        .busy_o          (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int coin_value(input bit [1:0] t);
        case (t)
            2'd0: return 5;
            2'd1: return 10;
            2'd2: return 20;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_credit = 0;
        m_disp   = 1'b0;
        m_ret    = 1'b0;
        m_reject = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit [1:0] t, input bit c, input bit a);
        bit nrej = 1'b0;
        if (!m_disp && !m_ret) begin
            if (c) begin
                if (m_credit > 0) begin
                    if (Chg) m_ret = 1'b1;
                    else m_credit = 0;
                end
            end else if (v) begin
                int val = coin_value(t);
                if (val < 0 || m_credit + val > CreditMax) begin
                    nrej = 1'b1;
                end else begin
                    m_credit += val;
                    if (m_credit >= Price) m_disp = 1'b1;
                end
            end
        end else if (m_disp) begin
            m_disp = 1'b0;
            if (Chg && m_credit - Price > 0) begin
                m_credit = m_credit - Price;
                m_ret    = 1'b1;
            end else begin
                m_credit = 0;
            end
        end else if (a) begin
            m_credit = 0;
            m_ret    = 1'b0;
        end
        m_reject = nrej;
    endtask

    task automatic compare_outputs(input bit c);
        check_eq("coin_ready", int'(coin_ready), int'(!m_disp && !m_ret && !c));
        check_eq("dispense", int'(dispense), int'(m_disp));
        check_eq("change_valid", int'(change_valid), int'(m_ret));
        check_eq("change_amount", int'(change_amount), m_ret ? m_credit : 0);
        check_eq("credit", int'(credit), m_credit);
        check_eq("busy", int'(busy), int'(m_disp || m_ret));
        check_eq("coin_reject", int'(coin_reject), int'(m_reject));
    endtask

    // entered and left at posedge+1
    task automatic cycle(input bit v, input bit [1:0] t, input bit c, input bit a);
        coin_valid = v;
        coin_type  = t;
        cancel     = c;
        change_ack = a;
        #1;
        compare_outputs(c);
        model_step(v, t, c, a);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b1;
        coin_valid = 1'b0;
        coin_type  = 2'd0;
        cancel     = 1'b0;
        change_ack = 1'b0;
        s_valid    = 1'b0;
        s_type     = 2'd0;
        model_reset();

        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_credit", int'(credit), 0);
        check_eq("rst_dispense", int'(dispense), 0);
        check_eq("rst_change_valid", int'(change_valid), 0);
        check_eq("rst_reject", int'(coin_reject), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 5 + 10 reaches price exactly: one dispense pulse, no change
        cycle(1, 2'd0, 0, 0);
        check_eq("seq1_credit5", int'(credit), 5);
        check_eq("seq1_no_disp", int'(dispense), 0);
        cycle(1, 2'd1, 0, 0);
        check_eq("seq1_credit15", int'(credit), 15);
        check_eq("seq1_disp", int'(dispense), 1);
        cycle(0, 2'd0, 0, 0);
        check_eq("seq1_disp_once", int'(dispense), 0);
        check_eq("seq1_credit0", int'(credit), 0);
        check_eq("seq1_no_change", int'(change_valid), 0);

        // 20 from zero: change of 5 held until ack
        cycle(1, 2'd2, 0, 0);
        check_eq("seq2_disp", int'(dispense), 1);
        cycle(0, 2'd0, 0, 0);
        check_eq("seq2_change_valid", int'(change_valid), Chg ? 1 : 0);
        check_eq("seq2_change_amt", int'(change_amount), Chg ? 5 : 0);
        check_eq("seq2_credit", int'(credit), Chg ? 5 : 0);
        for (int i = 0; i < 3; i++) cycle(0, 2'd0, 0, 0);
        check_eq("seq2_held", int'(change_amount), Chg ? 5 : 0);
        cycle(0, 2'd0, 0, 1);
        check_eq("seq2_ack_credit", int'(credit), 0);
        check_eq("seq2_ack_valid", int'(change_valid), 0);

        // coin 5 then cancel: refund, no dispense
        cycle(1, 2'd0, 0, 0);
        cycle(0, 2'd0, 1, 0);
        check_eq("seq3_refund_amt", int'(change_amount), Chg ? 5 : 0);
        check_eq("seq3_credit", int'(credit), Chg ? 5 : 0);
        check_eq("seq3_no_disp", int'(dispense), 0);
        cycle(0, 2'd0, 0, 1);
        check_eq("seq3_done", int'(credit), 0);

        // coin with cancel in the same cycle: no transfer, no reject
        cycle(1, 2'd1, 1, 0);
        check_eq("seq4_credit", int'(credit), 0);
        check_eq("seq4_no_reject", int'(coin_reject), 0);

        // invalid coin type
        cycle(1, 2'd0, 0, 0);
        cycle(1, 2'd3, 0, 0);
        check_eq("seq5_reject", int'(coin_reject), 1);
        check_eq("seq5_credit", int'(credit), 5);
        cycle(0, 2'd0, 0, 0);
        check_eq("seq5_reject_pulse", int'(coin_reject), 0);
        cycle(0, 2'd0, 1, 0);
        cycle(0, 2'd0, 0, 1);

        // asynchronous reset while change is pending
        cycle(1, 2'd2, 0, 0);
        cycle(0, 2'd0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_change_valid", int'(change_valid), 0);
        check_eq("arst_change_amt", int'(change_amount), 0);
        check_eq("arst_credit", int'(credit), 0);
        check_eq("arst_busy", int'(busy), 0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(0, 2'd0, 0, 0);
        check_eq("arst_ready", int'(coin_ready), 1);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 55), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 35));
        end
        cycle(0, 2'd0, 0, 1);
        cycle(0, 2'd0, 0, 1);

        // narrow instance: credit 10 + coin 10 overflows 4 bits
        s_valid = 1'b1;
        s_type  = 2'd0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_eq("w4_credit10", int'(s_credit), 10);
        s_type = 2'd1;
        @(posedge clk);
        #1;
        check_eq("w4_ovf_reject", int'(s_reject), 1);
        check_eq("w4_ovf_credit", int'(s_credit), 10);
        check_eq("w4_ovf_no_disp", int'(s_dispense), 0);
        s_type = 2'd2;
        @(posedge clk);
        #1;
        check_eq("w4_big_reject", int'(s_reject), 1);
        check_eq("w4_big_credit", int'(s_credit), 10);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("w4_reject_clear", int'(s_reject), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
